// File: rtl/frame_stream_driver_pkg.sv
// frame_stream_driver_pkg
//   Shared definitions for the frame stream driver.
//   - FSM state encoding
//   - counter width helpers (pixel, flush-beat and channel counters)
//   - fp32 zero used as the data value on flush beats
package frame_stream_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } fsd_state_e;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit counter
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // pixel index 0 .. WIDTH*HEIGHT-1
  function automatic int pix_cnt_w(input int w, input int h);
    return clog2_min1(w * h);
  endfunction

  // flush beat count 0 .. WIDTH+1 (WIDTH+1 means all flush beats issued)
  function automatic int flush_cnt_w(input int w);
    return clog2_min1(w + 2);
  endfunction

  // channel index 0 .. CHANNELS-1
  function automatic int ch_cnt_w(input int c);
    return clog2_min1(c);
  endfunction

endpackage

// File: rtl/frame_stream_pipe.sv
// frame_stream_pipe
//   Two-stage beat pipe matching the one-cycle memory read latency.
//   Stage 1 carries the beat attributes while the memory returns data;
//   stage 2 registers the beat onto the output, forcing data to zero for
//   flush beats and idle cycles.
// Ports:
//   clk_i                 clock
//   clr_i                 synchronous clear (drops in-flight beats)
//   vld_i/flush_i/last_i  beat issued this cycle and its attributes
//   ch_i                  channel of the issued beat
//   rdata_i               memory read data (one cycle after issue)
//   vld_o/data_o/flush_o/ch_o/last_o  beat two cycles after issue
module frame_stream_pipe
  import frame_stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CH_W       = 1
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  vld_i,
  input  logic                  flush_i,
  input  logic                  last_i,
  input  logic [CH_W-1:0]       ch_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  flush_o,
  output logic [CH_W-1:0]       ch_o,
  output logic                  last_o
);

  logic [2:1]            vld_pipe_q;
  logic [2:1]            flush_pipe_q;
  logic [2:1]            last_pipe_q;
  logic [CH_W-1:0]       ch1_q, ch2_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_pipe_q   <= '0;
      flush_pipe_q <= '0;
      last_pipe_q  <= '0;
      ch1_q        <= '0;
      ch2_q        <= '0;
      data_q       <= '0;
    end else begin
      // attributes are qualified by valid so idle cycles leave zeros behind
      vld_pipe_q   <= {vld_pipe_q[1], vld_i};
      flush_pipe_q <= {flush_pipe_q[1], vld_i & flush_i};
      last_pipe_q  <= {last_pipe_q[1], vld_i & last_i};
      ch1_q        <= vld_i ? ch_i : '0;
      ch2_q        <= ch1_q;
      data_q       <= (vld_pipe_q[1] && !flush_pipe_q[1]) ? rdata_i
                                                          : DATA_WIDTH'(FP32_ZERO);
    end
  end

  assign vld_o   = vld_pipe_q[2];
  assign flush_o = flush_pipe_q[2];
  assign last_o  = last_pipe_q[2];
  assign ch_o    = ch2_q;
  assign data_o  = data_q;

endmodule

// File: rtl/frame_stream_driver.sv
// frame_stream_driver
//   Streams CHANNELS planes of WIDTH x HEIGHT pixels out of a synchronous-read
//   memory. After each plane WIDTH+1 zero-valued flush beats follow so a
//   line-buffer convolution downstream can drain its last row.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              pulse to begin a frame (ignored while busy)
//   hold               pause issue of reads / flush beats
//   mem_rd_en/mem_addr read request (addr = ch*WIDTH*HEIGHT + pixel)
//   mem_rdata          read data, one cycle after mem_rd_en
//   valid_out/data_out/flush_out/channel_out/last_out  output beat
//   busy, done         frame in progress / one-cycle completion pulse
// Optional build macro FRAME_STREAM_GAP_INJECT_EN: forces one idle cycle
//   after every GAP_PERIOD issued pixels (never during flush).
module frame_stream_driver
  import frame_stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56,
  parameter int CHANNELS   = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int GAP_PERIOD = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             hold,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             valid_out,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             flush_out,
  output logic [clog2_min1(CHANNELS)-1:0]  channel_out,
  output logic                             last_out,
  output logic                             busy,
  output logic                             done
);

  localparam int PLANE = WIDTH * HEIGHT;
  localparam int PIX_W = pix_cnt_w(WIDTH, HEIGHT);
  localparam int FL_W  = flush_cnt_w(WIDTH);
  localparam int CH_W  = ch_cnt_w(CHANNELS);

  localparam logic [PIX_W-1:0]      PIX_LAST = PIX_W'(PLANE - 1);
  localparam logic [FL_W-1:0]       FL_LAST  = FL_W'(WIDTH);      // index of final flush beat
  localparam logic [FL_W-1:0]       FL_END   = FL_W'(WIDTH + 1);  // all flush beats issued
  localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [ADDR_WIDTH-1:0] PLANE_A  = ADDR_WIDTH'(PLANE);

  // elaboration-time parameter sanity
  if ((64'd1 << ADDR_WIDTH) < 64'(CHANNELS * PLANE)) begin : g_addr_chk
    $error("ADDR_WIDTH too small for CHANNELS*WIDTH*HEIGHT");
  end
  if (GAP_PERIOD < 1) begin : g_gap_chk
    $error("GAP_PERIOD must be at least 1");
  end

  fsd_state_e            state_q, state_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [FL_W-1:0]       fl_q, fl_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;   // ch*PLANE, kept incrementally

  logic bubble, pix_issue, fl_issue, beat_last;

  assign pix_issue = (state_q == ST_STREAM) && !hold && !bubble;
  assign fl_issue  = (state_q == ST_FLUSH) && !hold && (fl_q != FL_END);
  assign beat_last = fl_issue && (fl_q == FL_LAST) && (ch_q == CH_LAST);

`ifdef FRAME_STREAM_GAP_INJECT_EN
  localparam int               GP_W    = clog2_min1(GAP_PERIOD);
  localparam logic [GP_W-1:0]  GP_LAST = GP_W'(GAP_PERIOD - 1);

  logic [GP_W-1:0] gcnt_q, gcnt_d;
  logic            gpend_q, gpend_d;

  // a pending bubble costs one STREAM cycle whether or not hold is also high
  assign bubble = (state_q == ST_STREAM) && gpend_q;

  always_comb begin
    gcnt_d  = gcnt_q;
    gpend_d = gpend_q;
    if (state_q != ST_STREAM) begin
      gcnt_d  = '0;
      gpend_d = 1'b0;
    end else if (gpend_q) begin
      gpend_d = 1'b0;
    end else if (pix_issue) begin
      if (gcnt_q == GP_LAST) begin
        gcnt_d  = '0;
        gpend_d = 1'b1;
      end else begin
        gcnt_d = gcnt_q + GP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt_q  <= '0;
      gpend_q <= 1'b0;
    end else begin
      gcnt_q  <= gcnt_d;
      gpend_q <= gpend_d;
    end
  end
`else
  assign bubble = 1'b0;
`endif

  // state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      fl_q    <= '0;
      ch_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      fl_q    <= fl_d;
      ch_q    <= ch_d;
      base_q  <= base_d;
    end
  end

  // next state; plane transitions happen on the issuing cycle so pixels and
  // flush beats run back to back without a dead cycle
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    fl_d    = fl_q;
    ch_d    = ch_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        pix_d  = '0;
        fl_d   = '0;
        ch_d   = '0;
        base_d = '0;
        if (start) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (pix_issue) begin
          if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            state_d = ST_FLUSH;
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (fl_issue) begin
          if ((fl_q == FL_LAST) && (ch_q != CH_LAST)) begin
            fl_d    = '0;
            ch_d    = ch_q + CH_W'(1);
            base_d  = base_q + PLANE_A;
            state_d = ST_STREAM;
          end else begin
            fl_d = fl_q + FL_W'(1);
          end
        end else if ((fl_q == FL_END) && last_out) begin
          // final beat is on the output now; done follows next cycle
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    mem_rd_en = pix_issue;
    mem_addr  = pix_issue ? (base_q + ADDR_WIDTH'(pix_q)) : '0;
    busy      = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
    done      = (state_q == ST_DONE);
  end

  frame_stream_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .CH_W       (CH_W)
  ) u_pipe (
    .clk_i   (clk),
    .clr_i   (reset),
    .vld_i   (pix_issue | fl_issue),
    .flush_i (fl_issue),
    .last_i  (beat_last),
    .ch_i    (ch_q),
    .rdata_i (mem_rdata),
    .vld_o   (valid_out),
    .data_o  (data_out),
    .flush_o (flush_out),
    .ch_o    (channel_out),
    .last_o  (last_out)
  );

endmodule

// File: tb/tb_frame_stream_driver.sv
// tb_frame_stream_driver
//   Directed bench for frame_stream_driver (WIDTH=4, HEIGHT=2, CHANNELS=3).
//   A queue-based beat model predicts every output cycle; literal expectations
//   pin latency, beat counts, hold gaps and reset abort behaviour.
module tb_frame_stream_driver;

  localparam int DW = 32, W = 4, H = 2, CH = 3, AW = 16, GP = 2;
  localparam int WH = W * H;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, hold = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          valid_out, flush_out, last_out, busy, done;
  logic [DW-1:0] data_out;
  logic [1:0]    channel_out;

  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  frame_stream_driver #(
    .DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .CHANNELS(CH),
    .ADDR_WIDTH(AW), .GAP_PERIOD(GP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .valid_out(valid_out), .data_out(data_out), .flush_out(flush_out),
    .channel_out(channel_out), .last_out(last_out), .busy(busy), .done(done)
  );

  // memory[i] = i; garbage when not read so stray captures show up
  always @(posedge clk) mem_rdata <= mem_rd_en ? DW'(mem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- beat model ----------------
  typedef struct packed {
    logic          vld;
    logic          flush;
    logic          last;
    logic [1:0]    ch;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } beat_t;

  beat_t q[$];
  beat_t p1 = '0, p2 = '0;
  bit    m_busy = 0, m_done = 0, bub = 0;
  int    plane_pix = 0;

  always @(posedge clk) begin : model
    beat_t nb;
    bit    was_last, accept;
    if (reset) begin
      q.delete();
      p1 = '0; p2 = '0; m_busy = 0; m_done = 0; bub = 0; plane_pix = 0;
    end else begin
      accept   = start && !m_busy && !m_done;
      was_last = p2.vld && p2.last;
      nb = '0;
      if (m_busy && q.size() > 0) begin
        if (bub) bub = 0;
        else if (!hold) begin
          nb = q.pop_front();
          nb.vld = 1'b1;
          if (nb.flush) plane_pix = 0;
          else begin
            plane_pix++;
`ifdef FRAME_STREAM_GAP_INJECT_EN
            if ((plane_pix % GP) == 0 && q.size() > 0 && !q[0].flush) bub = 1;
`endif
          end
        end
      end
      p2 = p1;
      p1 = nb;
      m_done = was_last;
      if (was_last) m_busy = 0;
      if (accept) begin
        for (int c = 0; c < CH; c++) begin
          for (int p = 0; p < WH; p++) begin
            nb = '0;
            nb.ch = 2'(c); nb.data = DW'(c * WH + p); nb.addr = AW'(c * WH + p);
            q.push_back(nb);
          end
          for (int f = 0; f <= W; f++) begin
            nb = '0;
            nb.flush = 1'b1; nb.ch = 2'(c);
            nb.last = (c == CH - 1) && (f == W);
            q.push_back(nb);
          end
        end
        m_busy = 1; plane_pix = 0; bub = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    bit erd;
    if (chk_en) begin
      erd = 1'b0;
      if (q.size() > 0) erd = m_busy && !hold && !bub && !q[0].flush;
      chk("valid_out", 32'(valid_out), 32'(p2.vld));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(erd));
      if (erd) chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
      if (p2.vld) begin
        chk("data_out", data_out, p2.data);
        chk("flush_out", 32'(flush_out), 32'(p2.flush));
        chk("channel_out", 32'(channel_out), 32'(p2.ch));
        chk("last_out", 32'(last_out), 32'(p2.last));
      end
    end
  end

  // ---------------- frame driver / literal stats ----------------
  task automatic frame(input int hold_after, input int hold_len, input bit restart_mid,
                       input bit abort_ch1,
                       output int nv, output int nf, output int nd, output int first_v,
                       output logic [31:0] first_d, output int t_last, output int t_done,
                       output int max_gap, output int seq_err, output int npix);
    int t, nrd, hcnt, gap, post;
    bit seen;
    nv = 0; nf = 0; nd = 0; first_v = -1; first_d = '1; t_last = -1; t_done = -1;
    max_gap = 0; seq_err = 0; npix = 0;
    t = 0; nrd = 0; hcnt = 0; gap = 0; seen = 0;
    start = 1'b1;
    while (t < 400) begin
      @(posedge clk); #1;
      t++;
      start = restart_mid && (t == 10);
      hold  = (hold_len > 0) && (nrd >= hold_after) && (hcnt < hold_len);
      if (hold) hcnt++;
      #1;
      if (mem_rd_en) nrd++;
      if (valid_out) begin
        if (!seen) begin seen = 1; first_v = t; first_d = data_out; end
        else if (gap > max_gap) max_gap = gap;
        gap = 0; nv++;
        if (flush_out) nf++;
        else begin
          if (data_out !== 32'(npix)) seq_err++;
          npix++;
        end
        if (last_out) t_last = t;
      end else if (seen) gap++;
      if (done) begin nd++; t_done = t; end
      if (abort_ch1 && valid_out && flush_out && channel_out == 2'd1) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; hold = 1'b0; start = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(valid_out), 0);
        chk("abort_data", data_out, 0);
        chk("abort_rd_en", 32'(mem_rd_en), 0);
        chk("abort_done", 32'(done), 0);
        post = 0;
        repeat (10) begin
          @(posedge clk); #2;
          if (done || valid_out || busy || mem_rd_en) post++;
        end
        chk("abort_quiet_cycles", 32'(post), 0);
        return;
      end
      if (t_done >= 0 && t > t_done + 2) break;
    end
    hold = 1'b0; start = 1'b0;
    if (abort_ch1) chk("abort_point_reached", 0, 1);
    else chk("frame_done_seen", 32'(t_done >= 0), 1);
  endtask

  initial begin
    int nv, nf, nd, fv, tl, td, mg, se, np;
    logic [31:0] fd;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_data", data_out, 0);
    chk("rst_flush", 32'(flush_out), 0);
    chk("rst_last", 32'(last_out), 0);
    chk("rst_channel", 32'(channel_out), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // A: plain frame, extra start while busy
    frame(0, 0, 1, 0, nv, nf, nd, fv, fd, tl, td, mg, se, np);
    chk("A_first_valid_cycle", 32'(fv), 3);
    chk("A_first_data", fd, 0);
    chk("A_valid_beats", 32'(nv), 39);
    chk("A_flush_beats", 32'(nf), 15);
    chk("A_done_count", 32'(nd), 1);
    chk("A_done_after_last", 32'(td - tl), 1);
    chk("A_seq_err", 32'(se), 0);
    chk("A_pixels", 32'(np), 24);
`ifndef FRAME_STREAM_GAP_INJECT_EN
    chk("A_done_cycle", 32'(td), 42);
    chk("A_max_gap", 32'(mg), 0);
`endif

    // B: hold for 3 cycles after 3 reads issued
    frame(3, 3, 0, 0, nv, nf, nd, fv, fd, tl, td, mg, se, np);
    chk("B_valid_beats", 32'(nv), 39);
    chk("B_done_count", 32'(nd), 1);
    chk("B_seq_err", 32'(se), 0);
    chk("B_pixels", 32'(np), 24);
`ifndef FRAME_STREAM_GAP_INJECT_EN
    chk("B_max_gap", 32'(mg), 3);
    chk("B_done_cycle", 32'(td), 45);
`endif

    // C: reset during channel 1 flush
    frame(0, 0, 0, 1, nv, nf, nd, fv, fd, tl, td, mg, se, np);
    chk("C_done_count", 32'(nd), 0);

    // D: fresh frame replays from address 0
    frame(0, 0, 0, 0, nv, nf, nd, fv, fd, tl, td, mg, se, np);
    chk("D_first_data", fd, 0);
    chk("D_valid_beats", 32'(nv), 39);
    chk("D_done_count", 32'(nd), 1);
    chk("D_seq_err", 32'(se), 0);
`ifndef FRAME_STREAM_GAP_INJECT_EN
    chk("D_done_cycle", 32'(td), 42);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
